// File: rtl/mem_access_pkg.sv
// Shared widths, flow/opcode encodings and MEM-stage FSM states for the rooth core.
package mem_access_pkg;
  localparam int CPU_WIDTH  = 32;
  localparam int FLOW_WIDTH = 2;
  localparam int NUM_LANES  = CPU_WIDTH / 8;

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_lane_gen.sv
// Per-byte-lane byte enable and store-data replication, plus alignment check.
module mem_lane_gen
  import mem_access_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           addr_lo,
  input  logic                 is_store,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [NUM_LANES-1:0] be,
  output logic [CPU_WIDTH-1:0] lane_wdata,
  output logic                 misalign
);
  assign misalign = misaligned(size, addr_lo);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LANE = 2'(g);
    // Halfword lanes pair up on addr[1]; only aligned halfwords reach the bus.
    assign be[g] = !is_store       ? 1'b1 :
                   (size == SZ_B)  ? (addr_lo == LANE) :
                   (size == SZ_H)  ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign lane_wdata[8*g +: 8] = (is_store && size == SZ_B) ? wdata[7:0] :
                                  (is_store && size == SZ_H) ? wdata[8*(g%2) +: 8] :
                                  wdata[8*g +: 8];
  end
endmodule

// File: rtl/mem_access.sv
// MEM stage: decodes load/store, runs the req/gnt/rvalid data-bus handshake and
// stalls the pipe until the access completes; feeds if_wb with the load word.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLOW_WIDTH-1:0] flow_mem_i,
  input  logic [CPU_WIDTH-1:0]  inst_i,
  input  logic [CPU_WIDTH-1:0]  mem_addr_i,
  input  logic [CPU_WIDTH-1:0]  mem_wdata_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [CPU_WIDTH-1:0]  dbus_addr_o,
  output logic [NUM_LANES-1:0]  dbus_be_o,
  output logic [CPU_WIDTH-1:0]  dbus_wdata_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [CPU_WIDTH-1:0]  dbus_rdata_i,
  input  logic                  dbus_err_i,
  output logic                  stall_req_o,
  output logic [CPU_WIDTH-1:0]  data_mem_data_o,
  output logic [1:0]            mem_addr_index_o,
  output logic                  no_writing_mem_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_ld;
  logic               ld_ok;
  logic               is_load, is_store, mem_op, mis, issue, refresh, tmo;
  logic [NUM_LANES-1:0] be;
  logic [CPU_WIDTH-1:0] lane_wdata;
  logic               unused_bits;

  assign is_load  = inst_i[6:0] == OPC_LOAD;
  assign is_store = inst_i[6:0] == OPC_STORE;
  assign mem_op   = is_load || is_store;
  assign refresh  = flow_mem_i == FLOW_REFRESH;
  // Gated by rst_n so a held instruction cannot raise stall while in reset.
  assign issue    = rst_n && state == S_IDLE && mem_op && !mis && flow_mem_i == FLOW_WORK;
  assign tmo      = (TIMEOUT_CYCLES != 0) && (state == S_ADDR || state == S_DATA) &&
                    cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign unused_bits = &{1'b0, inst_i[31:15], inst_i[11:7], inst_i[14]};

  mem_lane_gen u_lane (
    .size       (inst_i[13:12]),
    .addr_lo    (mem_addr_i[1:0]),
    .is_store   (is_store),
    .wdata      (mem_wdata_i),
    .be         (be),
    .lane_wdata (lane_wdata),
    .misalign   (mis)
  );

  assign stall_req_o = issue || state == S_ADDR || state == S_DATA || state == S_DRAIN;
  assign no_writing_mem_o = !(state == S_DONE && ld_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      is_ld            <= 1'b0;
      ld_ok            <= 1'b0;
      dbus_req_o       <= 1'b0;
      dbus_we_o        <= 1'b0;
      dbus_addr_o      <= '0;
      dbus_be_o        <= '0;
      dbus_wdata_o     <= '0;
      data_mem_data_o  <= '0;
      mem_addr_index_o <= '0;
      misalign_o       <= 1'b0;
      bus_err_o        <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state            <= S_ADDR;
            cnt              <= '0;
            is_ld            <= is_load;
            ld_ok            <= 1'b0;
            dbus_req_o       <= 1'b1;
            dbus_we_o        <= is_store;
            dbus_addr_o      <= {mem_addr_i[CPU_WIDTH-1:2], 2'b00};
            dbus_be_o        <= be;
            dbus_wdata_o     <= lane_wdata;
            mem_addr_index_o <= mem_addr_i[1:0];
          end else if (mem_op && mis && flow_mem_i == FLOW_WORK) begin
            misalign_o <= 1'b1;
          end
        end
        S_ADDR: begin
          cnt <= cnt + 1'b1;
          if (dbus_gnt_i) begin
            // Accepted together with a flush: a response is still owed, so drain it.
            dbus_req_o <= 1'b0;
            state      <= refresh ? S_DRAIN : S_DATA;
          end else if (refresh) begin
            dbus_req_o <= 1'b0;
            state      <= S_IDLE;
          end else if (tmo) begin
            dbus_req_o <= 1'b0;
            bus_err_o  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DATA: begin
          cnt <= cnt + 1'b1;
          if (refresh) begin
            state <= dbus_rvalid_i ? S_IDLE : S_DRAIN;
          end else if (dbus_rvalid_i) begin
            state <= S_DONE;
            if (dbus_err_i) begin
              bus_err_o <= 1'b1;
            end else if (is_ld) begin
              data_mem_data_o <= dbus_rdata_i;
              ld_ok           <= 1'b1;
            end
          end else if (tmo) begin
            bus_err_o <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DRAIN: if (dbus_rvalid_i) state <= S_IDLE;
        S_DONE:  if (flow_mem_i != FLOW_STOP) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
